// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - single-port memory arbiter: display owns active video, host gets blanking slots
// Optional macro HOST_READ_EN adds the host read path (READ/RD_WAIT states).
module vga_mem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int GUARD    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       wait_cnt,
  output logic              err
);

  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] H_CLOSE = 10'(H_TOTAL - GUARD);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

`ifdef HOST_READ_EN
  typedef enum logic [1:0] {IDLE, WRITE, READ, RD_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

  state_t              state;
  logic [ADDR_W-1:0]   host_addr_q;
  logic [DATA_W-1:0]   host_wdata_q;
  logic                v_blank;
  logic                h_blank;
  logic                window;
  logic                active_video;
  logic                wait_sat;

  // The last GUARD cycles of the final blanking line belong to the display,
  // so a transaction started there still finishes before line 0 begins.
  assign v_blank      = (pixel_y >= V_ACT) && !((pixel_y == V_LAST) && (pixel_x >= H_CLOSE));
  assign h_blank      = (pixel_x >= H_ACT) && (pixel_x < H_CLOSE);
  assign window       = v_blank || h_blank;
  assign active_video = (pixel_x < H_ACT) && (pixel_y < V_ACT);
  assign wait_sat     = (wait_cnt == 16'hFFFF);

  assign mem_addr  = (state == IDLE) ? disp_addr : host_addr_q;
  assign mem_wdata = host_wdata_q;

`ifndef HOST_READ_EN
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign host_rdata   = '0;
  assign host_rvalid  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
      host_ack     <= 1'b0;
      mem_we       <= 1'b0;
      wait_cnt     <= '0;
      err          <= 1'b0;
`ifdef HOST_READ_EN
      host_rdata   <= '0;
      host_rvalid  <= 1'b0;
`endif
    end else begin
      host_ack <= 1'b0;
      mem_we   <= 1'b0;
`ifdef HOST_READ_EN
      host_rvalid <= 1'b0;
`endif
      if ((state != IDLE) && active_video)
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (host_req && host_we) begin
            if (window) begin
              state        <= WRITE;
              host_ack     <= 1'b1;
              mem_we       <= 1'b1;
              host_addr_q  <= host_addr;
              host_wdata_q <= host_wdata;
              wait_cnt     <= '0;
            end else if (!wait_sat) begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end else if (host_req) begin
`ifdef HOST_READ_EN
            if (window) begin
              state       <= READ;
              host_ack    <= 1'b1;
              host_addr_q <= host_addr;
              wait_cnt    <= '0;
            end else if (!wait_sat) begin
              wait_cnt <= wait_cnt + 16'd1;
            end
`else
            // Reads are acknowledged without touching memory; the request is
            // still high during the ack cycle and must not be acked twice.
            if (!host_ack) begin
              host_ack <= 1'b1;
              wait_cnt <= '0;
            end
`endif
          end
        end
        WRITE: state <= IDLE;
`ifdef HOST_READ_EN
        READ: state <= RD_WAIT;
        RD_WAIT: begin
          host_rdata  <= mem_rdata;
          host_rvalid <= 1'b1;
          state       <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - randomized self-checking bench for vga_mem_arbiter
// Honors HOST_READ_EN the same way as the design.
module tb_vga_mem_arbiter;

  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 8;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int GUARD    = 3;
  localparam int BOUND    = 2000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  int                px = 0;
  int                py = 0;
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       wait_cnt;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  bit   [DATA_W-1:0] mem [1<<ADDR_W];
  bit                written [1<<ADDR_W];
  logic [DATA_W-1:0] ref_mem [int];

  assign pixel_x = 10'(px);
  assign pixel_y = 10'(py);

  always #5 clk = ~clk;

  vga_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL), .GUARD(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .disp_addr(disp_addr),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wait_cnt(wait_cnt), .err(err)
  );

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    int ai;
    ai = int'(a);
    if (a == 13'h1000) return 8'hC3;
    return 8'((ai * 7) ^ (ai >> 5) ^ 33);
  endfunction

  // Memory macro: one-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
  end

  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic bit win(input int x, input int y);
    bit vb, hb;
    vb = (y >= V_ACTIVE) && !((y == V_TOTAL - 1) && (x >= H_TOTAL - GUARD));
    hb = (x >= H_ACTIVE) && (x < H_TOTAL - GUARD);
    return vb || hb;
  endfunction

  task automatic step(inout int x, inout int y);
    if (x >= H_TOTAL - 1) begin
      x = 0;
      y = (y >= V_TOTAL - 1) ? 0 : y + 1;
    end else begin
      x = x + 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step(px, py);
    disp_addr = ADDR_W'($urandom);
    #1;
  endtask

  task automatic do_req(input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input int x0, input int y0);
    int n, x, y, c, ack_c;
    logic [15:0] wc_prev;
    bit disp_bad, rd_bad;
    px = x0;
    py = y0;
    host_req = 1'b1;
    host_we = we;
    host_addr = addr;
    host_wdata = data;
    disp_addr = ADDR_W'($urandom);
    #1;
    n = 0;
    x = x0;
    y = y0;
    while (!win(x, y) && n < BOUND) begin
      n++;
      step(x, y);
    end
`ifndef HOST_READ_EN
    if (!we) n = 0;
`endif
    c = 0;
    ack_c = -1;
    disp_bad = 1'b0;
    wc_prev = wait_cnt;
    while (c < BOUND) begin
      wc_prev = wait_cnt;
      if (mem_we || (mem_addr != disp_addr)) disp_bad = 1'b1;
      tick();
      c++;
      if (host_ack) begin
        ack_c = c;
        break;
      end
    end
    check("ack_cycle", 32'(ack_c), 32'(n + 1));
    check("disp_pass", 32'(disp_bad), 32'd0);
    check("wait_at_grant", 32'(wc_prev), 32'((n > 65535) ? 65535 : n));
    if (we) begin
      check("wr_we", 32'(mem_we), 32'd1);
      check("wr_addr", 32'(mem_addr), 32'(addr));
      check("wr_data", 32'(mem_wdata), 32'(data));
      ref_mem[int'(addr)] = data;
    end else begin
      check("rd_no_we", 32'(mem_we), 32'd0);
`ifdef HOST_READ_EN
      check("rd_addr", 32'(mem_addr), 32'(addr));
`endif
    end
    tick();
    host_req = 1'b0;
    check("ack_pulse", 32'(host_ack), 32'd0);
    if (we) check("wr_we_pulse", 32'(mem_we), 32'd0);
`ifdef HOST_READ_EN
    if (!we) begin
      check("rd_early", 32'(host_rvalid), 32'd0);
      tick();
      check("rd_valid", 32'(host_rvalid), 32'd1);
      check("rd_data", 32'(host_rdata), 32'(exp_rd(addr)));
    end
    tick();
    check("rvalid_pulse", 32'(host_rvalid), 32'd0);
    rd_bad = 1'b0;
`else
    rd_bad = 1'b0;
    repeat (3) begin
      if (host_rvalid || (host_rdata != '0) || mem_we) rd_bad = 1'b1;
      tick();
    end
    check("no_read_path", 32'(rd_bad), 32'd0);
`endif
  endtask

  logic [ADDR_W-1:0] last_a;
  logic [ADDR_W-1:0] ra;
  bit                rw;
  bit                bad;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ack", 32'(host_ack), 32'd0);
    check("rst_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_rdata", 32'(host_rdata), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_wait_cnt", 32'(wait_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'(disp_addr));
    rst = 1'b1;
    tick();
    tick();

    do_req(1'b1, 13'h0123, 8'h5A, 100, 20);
`ifdef HOST_READ_EN
    do_req(1'b0, 13'h1000, 8'h00, 650, 5);
`else
    do_req(1'b0, 13'h1000, 8'h00, 10, 10);
`endif
    do_req(1'b1, ADDR_W'($urandom_range(0, 8189)), DATA_W'($urandom), 797, 100);
    do_req(1'b1, ADDR_W'($urandom_range(0, 8189)), DATA_W'($urandom), 797, 524);
`ifdef HOST_READ_EN
    do_req(1'b0, 13'h0123, 8'h00, 700, 200);
`endif

    last_a = 13'h0123;
    for (int i = 0; i < 12; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = ((i % 3) == 2) ? last_a : ADDR_W'($urandom_range(0, 8189));
      do_req(rw, ra, DATA_W'($urandom), int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
      last_a = ra;
    end
    check("err_clean", 32'(err), 32'd0);

    // Host holds the memory while the timing jumps into active video.
    px = 700;
    py = 10;
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 13'h1FFE;
    host_wdata = 8'h77;
    #1;
    tick();
    check("err_ack", 32'(host_ack), 32'd1);
    ref_mem[int'(13'h1FFE)] = 8'h77;
    px = 0;
    py = 10;
    tick();
    host_req = 1'b0;
    check("err_set", 32'(err), 32'd1);
    tick();
    tick();

    // Reset in the middle of a write.
    px = 700;
    py = 10;
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 13'h1FFF;
    host_wdata = 8'hA5;
    #1;
    tick();
    check("mid_ack", 32'(host_ack), 32'd1);
    check("mid_we", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_ack", 32'(host_ack), 32'd0);
    check("rst_mid_wait", 32'(wait_cnt), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    check("rst_mid_addr", 32'(mem_addr), 32'(disp_addr));
    host_req = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      tick();
      if (mem_we || host_ack || host_rvalid) bad = 1'b1;
    end
    check("post_rst_quiet", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Arbitrates the single-port tile/pixel memory between the display address generator and a host requester. The display path has absolute priority during active video. Host reads and writes are slotted into horizontal and vertical blanking using a req/ack handshake. The block sits between the tile address generator, the host/loader port and the memory macro.

## Interface
Parameters:
- ADDR_W, 13, memory address width
- DATA_W, 8, memory data width
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixel clocks per line
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame
- GUARD, 3, blanking cycles reserved before active video resumes

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- pixel_x  in  10  current column from the timing generator
- pixel_y  in  10  current line from the timing generator
- disp_addr  in  ADDR_W  display fetch address from the tile address generator
- host_req  in  1  host request; held until host_ack
- host_we  in  1  1 = write, 0 = read; valid with host_req
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  one-cycle pulse when the request is committed
- host_rdata  out  DATA_W  read data
- host_rvalid  out  1  one-cycle pulse; host_rdata valid
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; 1-cycle synchronous latency
- wait_cnt  out  16  cycles of the current request spent waiting for a slot; saturating
- err  out  1  sticky flag: host owned memory during active video

## Operation
- The window is open when either condition holds:
  - pixel_y >= V_ACTIVE, except on line V_TOTAL-1 with pixel_x >= H_TOTAL-GUARD.
  - H_ACTIVE <= pixel_x < H_TOTAL-GUARD.
- States:
  - IDLE → WRITE when host_req & host_we & window.
  - IDLE → READ when host_req & !host_we & window.
  - WRITE → IDLE.
  - READ → RD_WAIT → IDLE.
- The host address and data are registered on the grant edge into host_addr_q and host_wdata_q.
- mem_addr is a combinational mux: disp_addr in IDLE, host_addr_q otherwise. It adds no latency to the display path.
- mem_we = 1 only in WRITE. mem_wdata = host_wdata_q.
- host_ack pulses in the first cycle of WRITE or READ.
- The host must drop host_req the cycle after host_ack. If host_req is still high in IDLE, it is a new request.
- RD_WAIT captures mem_rdata into host_rdata. host_rvalid pulses the following cycle.
- wait_cnt:
  - Increments each cycle in IDLE with host_req high and the window closed.
  - Saturates at 0xFFFF.
  - Clears on grant.
- err sets if state != IDLE while pixel_x < H_ACTIVE and pixel_y < V_ACTIVE. It is cleared only by reset.
- Reset mid-transaction returns the block to IDLE. The pending ack or rvalid is lost. No mem_we is issued after reset deasserts until a new grant.

## Timing
- Reset values:
  - host_ack = 0, host_rvalid = 0, host_rdata = 0.
  - mem_we = 0, mem_wdata = 0.
  - wait_cnt = 0, err = 0.
  - mem_addr = disp_addr (IDLE).
- Write granted at edge T:
  - Cycle T+1: mem_we = 1, host_ack = 1.
  - Cycle T+2: IDLE.
- Read granted at edge T:
  - Cycle T+1: READ, host_ack = 1.
  - Cycle T+2: RD_WAIT, memory drives data.
  - Cycle T+3: host_rvalid = 1, IDLE.
- Maximum occupancy is 3 cycles, so GUARD >= 3 keeps every transaction inside blanking.
- A request arriving in the cycle the window closes waits for the next window.
- Back-to-back host requests cost at least one IDLE cycle between transactions.

## Configuration
- HOST_READ_EN defined: host reads are supported as described above.
- HOST_READ_EN undefined:
  - The READ and RD_WAIT states are removed.
  - host_rdata = 0 and host_rvalid = 0, both constant.
  - A read request is acked one cycle after it is seen in IDLE, regardless of the window.
  - A read request never touches the memory and never increments wait_cnt.

## Test plan
- Reset low mid-WRITE at pixel (700,10) → mem_we = 0, host_ack = 0, wait_cnt = 0, err = 0 immediately; mem_addr follows disp_addr.
- Write req at pixel (100,20) with addr 0x0123, data 0x5A → no grant until pixel_x = 640; wait_cnt = 540 at grant; mem_we pulse with mem_addr = 0x0123, mem_wdata = 0x5A.
- Read of 0x1000 (memory holds 0xC3) at pixel (650,5) → host_ack at +1 cycle, host_rvalid with host_rdata = 0xC3 at +3 cycles.
- Req at pixel (797,100) → no grant until pixel_x = 640 of line 101; display addresses are passed unchanged throughout.
- Req at pixel (797,524) → no grant until (640,0); err stays 0 through the whole test.
- HOST_READ_EN undefined: read req at pixel (10,10) → host_ack next cycle, mem_we = 0, host_rvalid never asserts.
